oh_fifo_drain: RTL and testbench

OH_FIFO_DRAIN -- requirements
Module: oh_fifo_drain

---
 rtl/oh_fifo_pkg.sv | 12 +
 rtl/oh_fifo_drain_chk.sv | 24 ++
 rtl/oh_regbuf2.sv | 77 +++++++
 rtl/oh_fifo_drain.sv | 87 ++++++++
 tb/tb_oh_fifo_drain.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/oh_fifo_pkg.sv
// Shared constants for the oh_fifo family.
// Holds the default data width of the upstream async FIFO and the depth of the
// local holding store used by the drain adapter.
package oh_fifo_pkg;

  localparam int OH_FIFO_DW        = 104;
  localparam int OH_FIFO_BUF_DEPTH = 2;

  // Local occupancy: 0..OH_FIFO_BUF_DEPTH entries.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/oh_fifo_drain_chk.sv
// Invariant checker for oh_fifo_drain (simulation only, no hardware).
// Ports: observes clk/reset/flush, the upstream FIFO handshake, and the
// holding-store push/pop/count of the drain adapter.
module oh_fifo_drain_chk (
  input logic       clk,
  input logic       reset,
  input logic       flush,
  input logic       fifo_empty,
  input logic       fifo_rd_en,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  a_occ_max: assert property (@(posedge clk) disable iff (reset)
    count <= 2'd2);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && (count == 2'd2)));

  a_no_read_empty: assert property (@(posedge clk) disable iff (reset)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: rtl/oh_regbuf2.sv
// Two-entry in-order holding store.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   flush         - drop all held entries at the next edge
//   push          - write push_data behind any remaining entry this edge
//   push_data     - entry to store
//   pop           - remove head entry this edge (caller guarantees count != 0)
//   head_data     - oldest held entry (don't-care when count == 0)
//   count         - number of held entries (0..2)
module oh_regbuf2
  import oh_fifo_pkg::*;
#(
  parameter int DW = OH_FIFO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] ent0_r;   // head entry
  logic [DW-1:0] ent1_r;   // second entry
  occ_t          count_r;

  // Entry counter: reset over flush over push/pop; push+pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Data entries carry no reset value; they are only meaningful below count_r.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            ent0_r <= push_data;
          end else begin
            ent1_r <= push_data;
          end
        end
        2'b01: begin
          ent0_r <= ent1_r;
        end
        2'b11: begin
          // With two held, the new word queues behind the survivor;
          // with one held, the head drains and the new word becomes head.
          if (count_r == 2'd2) begin
            ent0_r <= ent1_r;
            ent1_r <= push_data;
          end else begin
            ent0_r <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_data = ent0_r;
  assign count     = count_r;

endmodule

// File: rtl/oh_fifo_drain.sv
// Drain adapter: turns an async FIFO read port (strobe now, data next cycle)
// into a valid/ready stream through a two-entry holding store.
// Ports:
//   clk, reset    - FIFO read clock, synchronous active-high reset
//   flush         - drop buffered and in-flight data
//   fifo_empty    - upstream empty flag
//   fifo_dout     - upstream read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    - upstream read strobe (combinational on out_ready)
//   out_valid     - out_data holds a beat
//   out_ready     - downstream accepts a beat
//   out_data      - head-of-buffer data
//   occupancy     - entries held locally (0..2)
module oh_fifo_drain
  import oh_fifo_pkg::*;
#(
  parameter int DW = OH_FIFO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  localparam logic [2:0] BUF_DEPTH = 3'(OH_FIFO_BUF_DEPTH);

  logic       inflight_r;
  logic       pop_s;
  logic       push_s;
  occ_t       count_s;
  logic [2:0] credit_s;
  logic [2:0] limit_s;

  assign out_valid = (count_s != 2'd0);
  assign pop_s     = out_valid & out_ready;

  // A word landing in the flush cycle belongs to the dropped stream.
  assign push_s    = inflight_r & ~flush;

  // Credit test written as (held + inflight < depth + pop) to avoid underflow.
  assign credit_s   = {1'b0, count_s} + {2'b00, inflight_r};
  assign limit_s    = BUF_DEPTH + {2'b00, pop_s};
  assign fifo_rd_en = ~fifo_empty & ~flush & ~reset & (credit_s < limit_s);

  // Tracks a read whose data appears on fifo_dout this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_r <= 1'b0;
    end else if (flush) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fifo_rd_en;
    end
  end

  oh_regbuf2 #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_s),
    .push_data (fifo_dout),
    .pop       (pop_s),
    .head_data (out_data),
    .count     (count_s)
  );

  assign occupancy = count_s;

  oh_fifo_drain_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .push       (push_s),
    .pop        (pop_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_oh_fifo_drain.sv
// Self-checking bench for oh_fifo_drain. A behavioural FIFO supplies read data
// one cycle after fifo_rd_en; every word written to it is also queued as the
// expected output, and a monitor pops and compares on each accepted beat.
module tb_oh_fifo_drain;

  localparam int DW = 104;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          gate;
  int            rd_cnt;
  int            checks;
  int            errors;

  oh_fifo_drain #(.DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = gate || (fifo_q.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    upd_empty();
  endtask

  // Upstream FIFO model: read decided just before the edge, data shows after it.
  always @(negedge clk) begin
    logic [DW-1:0] pend;
    bit            have;
    #3;
    have = 1'b0;
    if (fifo_rd_en === 1'b1) begin
      chk("rd_while_empty", {{(DW-1){1'b0}}, fifo_empty}, {DW{1'b0}});
      if (fifo_q.size() > 0) begin
        pend = fifo_q.pop_front();
        have = 1'b1;
        rd_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (have) fifo_dout = pend;
    upd_empty();
  end

  // Scoreboard monitor: compares every accepted beat against the expected queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    #3;
    if (reset === 1'b0) begin
      checks++;
      if (occupancy > 2'd2) begin
        errors++;
        $display("FAIL occ_max actual=%0d required<=2", occupancy);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", out_data, e);
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    gate = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    upd_empty();
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
  endtask

  task automatic drain(input string name, input int max_cyc, input bit rnd);
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      if (exp_q.size() == 0 && fifo_q.size() == 0 && occupancy == 2'd0) break;
    end
    chk(name, DW'(exp_q.size()), {DW{1'b0}});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_cnt = 0;
    gate = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = {DW{1'b0}};

    // Reset held with a non-empty FIFO, then 0x1..0x8 stream with no gap.
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk("rst_rd_en", {{(DW-1){1'b0}}, fifo_rd_en}, {DW{1'b0}});
      chk("rst_valid", {{(DW-1){1'b0}}, out_valid}, {DW{1'b0}});
    end
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("first_rd_en", {{(DW-1){1'b0}}, fifo_rd_en}, {{(DW-1){1'b0}}, 1'b1});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #3;
      chk("stream_valid", {{(DW-1){1'b0}}, out_valid},
          {{(DW-1){1'b0}}, (k >= 2 && k <= 9)});
    end
    chk("t1_left", DW'(exp_q.size()), {DW{1'b0}});

    // Five words with a stalled consumer: two reads, then drain with no gap.
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_word(DW'(32'h10 + i));
    repeat (6) @(negedge clk);
    #3;
    chk("stall_reads", DW'(rd_cnt), DW'(2));
    chk("stall_occ", DW'(occupancy), DW'(2));
    chk("stall_rd_en", {{(DW-1){1'b0}}, fifo_rd_en}, {DW{1'b0}});
    chk("stall_head", out_data, DW'(32'h10));
    @(negedge clk);
    #3;
    chk("stall_hold", out_data, DW'(32'h10));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #3;
      chk("resume_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, (k < 5)});
    end
    chk("t2_left", DW'(exp_q.size()), {DW{1'b0}});

    // fifo_empty toggling every cycle: no read while empty, each word once.
    reset_dut();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DW'(32'h20 + i));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      gate = ~gate;
      upd_empty();
    end
    @(negedge clk);
    gate = 1'b0;
    upd_empty();
    drain("toggle_drain", 50, 1'b0);

    // Flush one cycle after a read with one word held.
    reset_dut();
    @(negedge clk);
    push_word(DW'(32'h30));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #3;
      if (occupancy == 2'd1) break;
    end
    chk("flush_pre_occ", DW'(occupancy), DW'(1));
    @(negedge clk);
    push_word(DW'(32'h31));
    #3;
    chk("flush_pre_rd", {{(DW-1){1'b0}}, fifo_rd_en}, {{(DW-1){1'b0}}, 1'b1});
    @(negedge clk);
    flush = 1'b1;
    #3;
    chk("flush_rd_en", {{(DW-1){1'b0}}, fifo_rd_en}, {DW{1'b0}});
    chk("flush_cyc_occ", DW'(occupancy), DW'(1));
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    #3;
    chk("flush_occ", DW'(occupancy), DW'(0));
    chk("flush_valid", {{(DW-1){1'b0}}, out_valid}, {DW{1'b0}});
    @(negedge clk);
    push_word(DW'(32'h32));
    out_ready = 1'b1;
    drain("flush_drain", 20, 1'b0);

    // 1000 incrementing words under random backpressure.
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < 1000; i++) push_word(DW'(32'h1000 + i));
    drain("random_drain", 5000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
